bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares one port of a byte-enabled, write-first, dual-ported BRAM between two requesters.
- Each requester issues read or byte-masked write beats through a valid/ready handshake.
- Round-robin arbitration, with an optional lock that holds the port for read-modify-write sequences.
- Tracks BRAM read latency (1 or 2 cycles) and routes each returned word back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 10, BRAM address width.
- DATA_WIDTH, 32, data word width.
- WE_WIDTH, 4, byte-enable count; DATA_WIDTH = 8*WE_WIDTH.
- PIPELINED, 0, must match the BRAM instance: 0 gives 1-cycle read latency, 1 gives 2-cycle read latency.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active high.
- REQ0_VALID  in  1  requester 0 beat valid.
- REQ0_READY  out  1  requester 0 beat accepted this cycle.
- REQ0_LOCK  in  1  hold grant after this beat.
- REQ0_WE  in  WE_WIDTH  byte enables; all zero means read.
- REQ0_ADDR  in  ADDR_WIDTH  word address.
- REQ0_DATA  in  DATA_WIDTH  write data.
- RSP0_VALID  out  1  response word for requester 0.
- RSP0_DATA  out  DATA_WIDTH  response data.
- REQ1_*, RSP1_*: identical set for requester 1.
- BRAM_EN  out  1  to BRAM port EN.
- BRAM_WE  out  WE_WIDTH  to BRAM port WE.
- BRAM_ADDR  out  ADDR_WIDTH  to BRAM port ADDR.
- BRAM_DI  out  DATA_WIDTH  to BRAM port DI.
- BRAM_DO  in  DATA_WIDTH  from BRAM port DO.

Behaviour:
- State: rr_ptr (1 bit, the preferred requester); lock_state in {UNLOCKED, LOCK0, LOCK1}; tag pipeline of 1+PIPELINED stages, each stage {valid, id}.
- Reset:
  - rr_ptr=0, lock_state=UNLOCKED, all tag stages invalid.
  - While RST=1: REQx_READY=0, BRAM_EN=0, RSPx_VALID=0.
- Grant (combinational, one grant per cycle):
  - UNLOCKED: if only one requester is valid, grant it. If both are valid, grant rr_ptr.
  - LOCKx: only requester x may be granted; the other requester's READY=0.
- REQx_READY = grant to x. A transfer occurs when VALID and READY are both 1.
- BRAM drive:
  - BRAM_EN = transfer this cycle.
  - BRAM_WE/ADDR/DI are muxed from the granted requester.
  - With no transfer, BRAM_EN=0 and BRAM_WE=0.
- rr_ptr: on a transfer from x, rr_ptr <= ~x at the edge. Otherwise unchanged.
- Lock transitions:
  - Transfer from x with REQx_LOCK=1: go to LOCKx.
  - In LOCKx, REQx_LOCK=0 at any edge (transfer or not): go to UNLOCKED.
  - A locked requester with VALID=0 and LOCK=1 idles the port; the other requester stalls.
- Response tracking:
  - Every transfer, read or write, produces exactly one response.
  - Write responses return the merged word (write-first).
  - On transfer, stage0 <= {1, id}; otherwise stage0 <= {0, -}. Stage1 <= stage0 when PIPELINED=1.
  - RSPx_VALID = last stage valid and id==x, driven as a registered flag.
  - RSPx_DATA = BRAM_DO, passed through and meaningful only while valid.
  - Latency from the transfer edge: 1 cycle (PIPELINED=0) or 2 cycles (PIPELINED=1).
- Throughput: one beat per cycle; back-to-back transfers give back-to-back responses in issue order.
- No response backpressure: the requester must take RSP in its valid cycle.
- RST asserted mid-operation: in-flight tags are discarded, so no responses follow reset. BRAM contents are not touched.

Optional Feature:
- Macro: BRAM_ARB_FIXED_PRIO_EN.
- Defined: in UNLOCKED with both requesters valid, requester 0 always wins; rr_ptr is not implemented. Lock behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, then REQ0 write WE=4'hF addr 5 data 32'hDEADBEEF; next cycle REQ0 read addr 5 -> RSP0_VALID 1 cycle after each transfer. Both responses carry 32'hDEADBEEF. RSP1_VALID stays 0.
- Both requesters hold reads continuously (REQ0 addr 1, REQ1 addr 2) for 6 cycles -> grants alternate 0,1,0,1,0,1; RSP ids follow the same sequence at +1 cycle (PIPELINED=0) and +2 cycles (PIPELINED=1 build).
- REQ1 read with LOCK=1, then REQ1 write WE=4'b0001 data 8'h5A with LOCK=0, REQ0 valid throughout -> REQ0_READY=0 for both cycles. REQ0 is granted in the cycle after the unlocking transfer. Write response shows low byte 8'h5A with upper bytes preserved.
- LOCK0 held with REQ0_VALID=0 for 3 cycles while REQ1 valid -> BRAM_EN=0 and REQ1_READY=0 throughout. Deasserting REQ0_LOCK lets REQ1 be granted next cycle.
- Read issued, then RST=1 on the following edge -> no RSP0_VALID appears; after reset REQ0_READY returns and rr_ptr=0.
- BRAM_ARB_FIXED_PRIO_EN build, both valid for 4 cycles -> REQ0 granted all 4 cycles, REQ1_READY=0.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Requester-side beat/response bundle for bram_port_arbiter.
// master = requester, slave = arbiter.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WE_WIDTH   = 4
);
  logic                  VALID;
  logic                  READY;
  logic                  LOCK;
  logic [WE_WIDTH-1:0]   WE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DATA;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_DATA;

  modport master (
    output VALID, LOCK, WE, ADDR, DATA,
    input  READY, RSP_VALID, RSP_DATA
  );

  modport slave (
    input  VALID, LOCK, WE, ADDR, DATA,
    output READY, RSP_VALID, RSP_DATA
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one write-first BRAM port between two requesters: round-robin grant, optional lock,
// read-latency tag tracking. Define BRAM_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WE_WIDTH   = 4,
  parameter int unsigned PIPELINED  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  bram_port_arbiter_if.slave    req0,
  bram_port_arbiter_if.slave    req1,
  output logic                  BRAM_EN,
  output logic [WE_WIDTH-1:0]   BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_state_t;

  lock_state_t lock_state;
  logic        gnt0_c;
  logic        gnt1_c;
  logic        xfer_c;
  logic [1:0]  rsp_vld_q;

`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic rr_ptr;

  // Preference flips to the requester that did not just transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= 1'b0;
    end else if (xfer_c) begin
      rr_ptr <= ~gnt1_c;
    end
  end
`endif

  // One grant per cycle; a held lock excludes the other requester entirely.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!RST) begin
      case (lock_state)
        LOCK0:   gnt0_c = req0.VALID;
        LOCK1:   gnt1_c = req1.VALID;
        default: begin
          if (req0.VALID && req1.VALID) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            gnt0_c = 1'b1;
`else
            gnt0_c = ~rr_ptr;
            gnt1_c = rr_ptr;
`endif
          end else begin
            gnt0_c = req0.VALID;
            gnt1_c = req1.VALID;
          end
        end
      endcase
    end
  end

  assign xfer_c     = gnt0_c | gnt1_c;
  assign req0.READY = gnt0_c;
  assign req1.READY = gnt1_c;

  assign BRAM_EN   = xfer_c;
  assign BRAM_WE   = gnt1_c ? req1.WE : (gnt0_c ? req0.WE : '0);
  assign BRAM_ADDR = gnt1_c ? req1.ADDR : req0.ADDR;
  assign BRAM_DI   = gnt1_c ? req1.DATA : req0.DATA;

  // Lock is taken by a locking transfer and dropped as soon as the owner releases LOCK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_state <= UNLOCKED;
    end else if (gnt0_c && req0.LOCK) begin
      lock_state <= LOCK0;
    end else if (gnt1_c && req1.LOCK) begin
      lock_state <= LOCK1;
    end else if ((lock_state == LOCK0 && !req0.LOCK) ||
                 (lock_state == LOCK1 && !req1.LOCK)) begin
      lock_state <= UNLOCKED;
    end
  end

  // Tag pipeline; the last stage is held decoded per requester.
  if (PIPELINED != 0) begin : g_two_stage
    logic stage0_vld;
    logic stage0_id;

    always_ff @(posedge CLK) begin
      if (RST) begin
        stage0_vld <= 1'b0;
        stage0_id  <= 1'b0;
        rsp_vld_q  <= 2'b00;
      end else begin
        stage0_vld <= xfer_c;
        stage0_id  <= gnt1_c;
        rsp_vld_q  <= {stage0_vld & stage0_id, stage0_vld & ~stage0_id};
      end
    end
  end else begin : g_one_stage
    always_ff @(posedge CLK) begin
      if (RST) begin
        rsp_vld_q <= 2'b00;
      end else begin
        rsp_vld_q <= {gnt1_c, gnt0_c};
      end
    end
  end

  assign req0.RSP_VALID = rsp_vld_q[0] & ~RST;
  assign req1.RSP_VALID = rsp_vld_q[1] & ~RST;
  assign req0.RSP_DATA  = BRAM_DO;
  assign req1.RSP_DATA  = BRAM_DO;

endmodule
